// File: rtl/servant_pm_pkg.sv
// ----------------------------------------------------------------------------
// servant_pm_pkg : shared state encoding and sizing helper for the clock PM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package servant_pm_pkg;

  localparam int unsigned PM_STATE_W = 3;

  typedef enum logic [PM_STATE_W-1:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_GATE0 = 3'd2,
    ST_GATE1 = 3'd3,
    ST_SLEEP = 3'd4,
    ST_WAKE1 = 3'd5,
    ST_WAKE0 = 3'd6
  } pm_state_e;

  // One spare bit above the longest interval so a load value can never wrap.
  function automatic int unsigned pm_cnt_width(input int unsigned drain_timeout,
                                               input int unsigned stagger,
                                               input int unsigned holdoff);
    int unsigned span;
    span = (drain_timeout > stagger + holdoff) ? drain_timeout : stagger + holdoff;
    return $clog2(span) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/servant_pm_timer.sv
// ----------------------------------------------------------------------------
// servant_pm_timer : loadable saturating down-counter with terminal-count flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module servant_pm_timer
  import servant_pm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tc = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/servant_clk_en_ctrl.sv
// ----------------------------------------------------------------------------
// servant_clk_en_ctrl : sleep/wake sequencer driving the core and bus BUFGCE enables
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module servant_clk_en_ctrl
  import servant_pm_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned STAGGER       = 4,
  parameter int unsigned WAKE_HOLDOFF  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sleep_req,
  input  logic                  i_wake,
  input  logic                  i_bus_busy,
  output logic                  o_clk0_en,
  output logic                  o_clk1_en,
  output logic                  o_sleeping,
  output logic                  o_sleep_abort,
  output logic [PM_STATE_W-1:0] o_state
);

  localparam int unsigned CNT_W = pm_cnt_width(DRAIN_TIMEOUT, STAGGER, WAKE_HOLDOFF);

  // Timer reaches zero after (load value + 1) cycles, hence the -1 on every interval.
  localparam logic [CNT_W-1:0] DRAIN_LOAD   = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] WAKE1_LOAD   = CNT_W'(STAGGER + WAKE_HOLDOFF - 1);

  pm_state_e        state_q;
  pm_state_e        state_d;
  logic             arm_q;
  logic             arm_d;
  logic             clk0_en_q;
  logic             clk0_en_d;
  logic             clk1_en_q;
  logic             clk1_en_d;
  logic             sleeping_q;
  logic             sleeping_d;
  logic             abort_q;
  logic             abort_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_tc;

  servant_pm_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .o_tc       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    arm_d        = arm_q;
    abort_d      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    // A timed-out request stays disarmed until the CSR bit is seen low again.
    if (!i_sleep_req) begin
      arm_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (i_sleep_req && arm_q && !i_wake) begin
          state_d      = ST_DRAIN;
          tmr_load     = 1'b1;
          tmr_load_val = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (i_wake) begin
          state_d = ST_RUN;
        end else if (!i_bus_busy) begin
          state_d      = ST_GATE0;
          tmr_load     = 1'b1;
          tmr_load_val = STAGGER_LOAD;
        end else if (tmr_tc) begin
          state_d = ST_RUN;
          abort_d = 1'b1;
          arm_d   = 1'b0;
        end
      end
      ST_GATE0: begin
        if (i_wake) begin
          state_d      = ST_WAKE0;
          tmr_load     = 1'b1;
          tmr_load_val = STAGGER_LOAD;
        end else if (tmr_tc) begin
          state_d = ST_GATE1;
        end
      end
      ST_GATE1: begin
        state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (i_wake) begin
          state_d      = ST_WAKE1;
          tmr_load     = 1'b1;
          tmr_load_val = WAKE1_LOAD;
        end
      end
      ST_WAKE1: begin
        if (tmr_tc) begin
          state_d      = ST_WAKE0;
          tmr_load     = 1'b1;
          tmr_load_val = STAGGER_LOAD;
        end
      end
      ST_WAKE0: begin
        if (tmr_tc) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Enables are decoded from the next state so they change on the entry edge.
    clk0_en_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_WAKE0);
    sleeping_d = (state_d == ST_GATE1) || (state_d == ST_SLEEP);
    clk1_en_d  = !sleeping_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      arm_q      <= 1'b1;
      clk0_en_q  <= 1'b1;
      clk1_en_q  <= 1'b1;
      sleeping_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      clk0_en_q  <= clk0_en_d;
      clk1_en_q  <= clk1_en_d;
      sleeping_q <= sleeping_d;
      abort_q    <= abort_d;
    end
  end

  assign o_clk0_en     = clk0_en_q;
  assign o_clk1_en     = clk1_en_q;
  assign o_sleeping    = sleeping_q;
  assign o_sleep_abort = abort_q;
  assign o_state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_servant_clk_en_ctrl.sv
// ----------------------------------------------------------------------------
// tb_servant_clk_en_ctrl : directed stimulus with a cycle-stamped expectation queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_servant_clk_en_ctrl;
  import servant_pm_pkg::*;

  logic       i_clk       = 1'b0;
  logic       i_rst       = 1'b1;
  logic       i_sleep_req = 1'b0;
  logic       i_wake      = 1'b0;
  logic       i_bus_busy  = 1'b0;
  logic       o_clk0_en;
  logic       o_clk1_en;
  logic       o_sleeping;
  logic       o_sleep_abort;
  logic [2:0] o_state;

  servant_clk_en_ctrl #(
    .DRAIN_TIMEOUT (64),
    .STAGGER       (4),
    .WAKE_HOLDOFF  (2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_sleep_req   (i_sleep_req),
    .i_wake        (i_wake),
    .i_bus_busy    (i_bus_busy),
    .o_clk0_en     (o_clk0_en),
    .o_clk1_en     (o_clk1_en),
    .o_sleeping    (o_sleeping),
    .o_sleep_abort (o_sleep_abort),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       c0;
    logic       c1;
    logic       slp;
    logic       ab;
    logic [2:0] st;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   errors      = 0;
  int   aborts_seen = 0;

  task automatic expect_at(input int c, input logic c0, input logic c1, input logic slp,
                           input logic ab, input logic [2:0] st, input string nm);
    exp_t e;
    e.cyc = c;
    e.c0  = c0;
    e.c1  = c1;
    e.slp = slp;
    e.ab  = ab;
    e.st  = st;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from state updates.
  always @(negedge i_clk) begin : mon
    exp_t e;
    checks++;
    if (o_clk0_en && !o_clk1_en) begin
      errors++;
      $display("FAIL invariant @cyc %0d: clk0_en=%b clk1_en=%b, clk0_en must imply clk1_en",
               cyc, o_clk0_en, o_clk1_en);
    end
    if (o_sleep_abort) aborts_seen++;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if ({o_clk0_en, o_clk1_en, o_sleeping, o_sleep_abort, o_state} !==
          {e.c0, e.c1, e.slp, e.ab, e.st}) begin
        errors++;
        $display("FAIL %s @cyc %0d: got c0=%b c1=%b slp=%b ab=%b st=%0d, want c0=%b c1=%b slp=%b ab=%b st=%0d",
                 e.nm, cyc, o_clk0_en, o_clk1_en, o_sleeping, o_sleep_abort, o_state,
                 e.c0, e.c1, e.slp, e.ab, e.st);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;

    // Reset state
    step(2);
    expect_at(cyc, 1, 1, 0, 0, ST_RUN, "reset_state");
    step(1);
    i_rst = 1'b0;
    step(2);

    // Clean sleep with idle bus
    r0 = cyc;
    i_bus_busy  = 1'b0;
    i_sleep_req = 1'b1;
    expect_at(r0 + 1, 1, 1, 0, 0, ST_DRAIN, "sleep_drain");
    expect_at(r0 + 2, 0, 1, 0, 0, ST_GATE0, "sleep_clk0_off");
    expect_at(r0 + 5, 0, 1, 0, 0, ST_GATE0, "sleep_stagger");
    expect_at(r0 + 6, 0, 0, 1, 0, ST_GATE1, "sleep_clk1_off");
    expect_at(r0 + 7, 0, 0, 1, 0, ST_SLEEP, "sleep_enter");
    expect_at(r0 + 9, 0, 0, 1, 0, ST_SLEEP, "sleep_hold");
    step(10);

    // Wake from SLEEP
    r0 = cyc;
    i_sleep_req = 1'b0;
    i_wake      = 1'b1;
    expect_at(r0 + 1,  0, 1, 0, 0, ST_WAKE1, "wake_clk1_on");
    expect_at(r0 + 6,  0, 1, 0, 0, ST_WAKE1, "wake_holdoff");
    expect_at(r0 + 7,  1, 1, 0, 0, ST_WAKE0, "wake_clk0_on");
    expect_at(r0 + 10, 1, 1, 0, 0, ST_WAKE0, "wake0_stagger");
    expect_at(r0 + 11, 1, 1, 0, 0, ST_RUN,   "wake_run");
    step(1);
    i_wake = 1'b0;
    step(12);

    // Drain timeout with the request held high
    r0 = cyc;
    i_bus_busy  = 1'b1;
    i_sleep_req = 1'b1;
    expect_at(r0 + 1,  1, 1, 0, 0, ST_DRAIN, "drain_enter");
    expect_at(r0 + 64, 1, 1, 0, 0, ST_DRAIN, "drain_last");
    expect_at(r0 + 65, 1, 1, 0, 1, ST_RUN,   "drain_abort");
    expect_at(r0 + 66, 1, 1, 0, 0, ST_RUN,   "abort_single");
    expect_at(r0 + 80, 1, 1, 0, 0, ST_RUN,   "no_retry");
    step(85);
    i_sleep_req = 1'b0;
    step(1);

    // Re-armed request, then wake at cycle 10 of DRAIN
    r0 = cyc;
    i_sleep_req = 1'b1;
    expect_at(r0 + 1,  1, 1, 0, 0, ST_DRAIN, "rearm_drain");
    expect_at(r0 + 9,  1, 1, 0, 0, ST_DRAIN, "drain_c9");
    expect_at(r0 + 10, 1, 1, 0, 0, ST_RUN,   "wake_in_drain");
    expect_at(r0 + 11, 1, 1, 0, 0, ST_RUN,   "drain_wake_no_abort");
    step(9);
    i_wake = 1'b1;
    step(1);
    i_wake      = 1'b0;
    i_sleep_req = 1'b0;
    i_bus_busy  = 1'b0;
    step(5);

    // Wake during GATE0
    r0 = cyc;
    i_sleep_req = 1'b1;
    expect_at(r0 + 1, 1, 1, 0, 0, ST_DRAIN, "g0_drain");
    expect_at(r0 + 2, 0, 1, 0, 0, ST_GATE0, "g0_enter");
    expect_at(r0 + 3, 0, 1, 0, 0, ST_GATE0, "g0_hold");
    expect_at(r0 + 4, 1, 1, 0, 0, ST_WAKE0, "g0_wake");
    expect_at(r0 + 7, 1, 1, 0, 0, ST_WAKE0, "g0_wake0_hold");
    expect_at(r0 + 8, 1, 1, 0, 0, ST_RUN,   "g0_run");
    step(3);
    i_wake = 1'b1;
    step(1);
    i_wake      = 1'b0;
    i_sleep_req = 1'b0;
    step(6);

    // Simultaneous request and wake in RUN
    r0 = cyc;
    i_sleep_req = 1'b1;
    i_wake      = 1'b1;
    expect_at(r0 + 1, 1, 1, 0, 0, ST_RUN, "simul_c1");
    expect_at(r0 + 3, 1, 1, 0, 0, ST_RUN, "simul_c3");
    step(3);
    i_sleep_req = 1'b0;
    i_wake      = 1'b0;
    step(2);

    // Asynchronous reset while sleeping
    r0 = cyc;
    i_sleep_req = 1'b1;
    expect_at(r0 + 7, 0, 0, 1, 0, ST_SLEEP, "rst_pre_sleep");
    expect_at(r0 + 8, 0, 0, 1, 0, ST_SLEEP, "rst_pre_hold");
    step(7);
    i_sleep_req = 1'b0;
    step(2);
    r0 = cyc;
    i_rst = 1'b1;
    expect_at(r0, 1, 1, 0, 0, ST_RUN, "rst_async");
    step(1);
    i_rst = 1'b0;
    expect_at(r0 + 3, 1, 1, 0, 0, ST_RUN, "rst_after");
    step(4);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step(1);
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations never reached, want 0", exp_q.size());
    end
    checks++;
    if (aborts_seen != 1) begin
      errors++;
      $display("FAIL abort_count: got %0d pulses, want 1", aborts_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
